// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants for the register-file write arbiter: default sizes and
// fixed requester slot assignments.
package regfile_write_arbiter_pkg;

   localparam int W = 8;
   localparam int D = 4;
   localparam int N = 3;

   localparam int REQ_ALU  = 0;
   localparam int REQ_LOAD = 1;
   localparam int REQ_OPS  = 2;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_select.sv
// Combinational round-robin pick: first occupied slot at or after ptr,
// wrapping modulo N. Holds no state.
module rr_select
   import regfile_write_arbiter_pkg::*;
#(
   parameter int N  = regfile_write_arbiter_pkg::N,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  occ,
   input  logic [IW-1:0] ptr,
   output logic          found,
   output logic [IW-1:0] sel_idx,
   output logic [N-1:0]  sel_onehot
);

   logic [IW-1:0] cand;

   always_comb begin
      found      = 1'b0;
      sel_idx    = '0;
      sel_onehot = '0;
      cand       = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = IW'((32'(ptr) + k) % 32'(N));
         if (!found && occ[cand]) begin
            found            = 1'b1;
            sel_idx          = cand;
            sel_onehot[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// N-requester register-file write arbiter: one holding slot per requester,
// round-robin issue of one registered write per cycle.
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int W = regfile_write_arbiter_pkg::W,
   parameter int D = regfile_write_arbiter_pkg::D,
   parameter int N = regfile_write_arbiter_pkg::N
) (
   input  logic           Clk,
   input  logic           Reset,
   input  logic [N-1:0]   ReqValid,
   input  logic [N*D-1:0] ReqAddr,
   input  logic [N*W-1:0] ReqData,
   output logic [N-1:0]   ReqReady,
   output logic           WrEn,
   output logic [D-1:0]   WrAddr,
   output logic [W-1:0]   WrData,
   output logic [N-1:0]   Grant,
   output logic           Busy
);

   localparam int IW = idx_w(N);

   logic [N-1:0]  occ_q, occ_d;
   logic [D-1:0]  addr_q [N];
   logic [D-1:0]  addr_d [N];
   logic [W-1:0]  data_q [N];
   logic [W-1:0]  data_d [N];
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic          wr_en_q, wr_en_d;
   logic [D-1:0]  wr_addr_q, wr_addr_d;
   logic [W-1:0]  wr_data_q, wr_data_d;
   logic [N-1:0]  grant_q, grant_d;

   logic          found;
   logic [IW-1:0] sel_idx;
   logic [N-1:0]  sel_onehot;
   logic [N-1:0]  issue_vec;
   logic [N-1:0]  xfer_vec;

   rr_select #(.N(N), .IW(IW)) u_rr_select (
      .occ        (occ_q),
      .ptr        (rr_ptr_q),
      .found      (found),
      .sel_idx    (sel_idx),
      .sel_onehot (sel_onehot)
   );

   // A slot being issued this cycle can accept a replacement on the same edge.
   assign issue_vec = found ? sel_onehot : '0;
   assign ReqReady  = ~occ_q | issue_vec;
   assign xfer_vec  = ReqValid & ReqReady;

   always_comb begin
      occ_d = occ_q;
      for (int unsigned i = 0; i < N; i++) begin
         occ_d[i]  = xfer_vec[i] | (occ_q[i] & ~issue_vec[i]);
         addr_d[i] = xfer_vec[i] ? ReqAddr[i*D +: D] : addr_q[i];
         data_d[i] = xfer_vec[i] ? ReqData[i*W +: W] : data_q[i];
      end

      wr_en_d   = found;
      grant_d   = issue_vec;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      rr_ptr_d  = rr_ptr_q;
      if (found) begin
         wr_addr_d = addr_q[sel_idx];
         wr_data_d = data_q[sel_idx];
         rr_ptr_d  = (sel_idx == IW'(N - 1)) ? '0 : sel_idx + 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      addr_q <= addr_d;
      data_q <= data_d;
      if (Reset) begin
         occ_q     <= '0;
         rr_ptr_q  <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         grant_q   <= '0;
      end else begin
         occ_q     <= occ_d;
         rr_ptr_q  <= rr_ptr_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         grant_q   <= grant_d;
      end
   end

   assign WrEn   = wr_en_q;
   assign WrAddr = wr_addr_q;
   assign WrData = wr_data_q;
   assign Grant  = grant_q;
   assign Busy   = (|occ_q) | wr_en_q;

endmodule
